// File: rtl/mac_vec_feeder_if.sv
// mac_vec_feeder_if: load stream in, MAC operand triples and status out.
interface mac_vec_feeder_if;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic [7:0] mac_a;
   logic [7:0] mac_b;
   logic [7:0] mac_x;
   logic       mac_valid;
   logic       busy;
   logic       done;
   modport master (output s_data, s_valid, input s_ready, mac_a, mac_b, mac_x, mac_valid, busy, done);
   modport slave (input s_data, s_valid, output s_ready, mac_a, mac_b, mac_x, mac_valid, busy, done);
endinterface

// File: rtl/mac_vec_feeder.sv
// mac_vec_feeder: buffers a W/v/bias job from a byte stream, then issues M_ROWS*VEC_S MAC operand triples.
module mac_vec_feeder #(
   parameter int M_ROWS = 3,
   parameter int VEC_S  = 3,
   parameter int GAP    = 0
) (
   input logic             clk,
   input logic             reset,
   mac_vec_feeder_if.slave bus
);
   localparam int MV = M_ROWS * VEC_S;
   localparam int N  = MV + VEC_S + M_ROWS;
   localparam int AW = $clog2(N + 1);
   localparam logic [0:0] LOAD  = 1'b0;
   localparam logic [0:0] ISSUE = 1'b1;
   logic [0:0]    state;
   logic [AW-1:0] ld_cnt, w_ptr, r, k;
   logic [3:0]    gap;
   logic [7:0]    mem [2**AW];
   logic          xfer, last_w, last_k, last_t;
   assign xfer   = bus.s_valid & bus.s_ready;
   assign last_w = ld_cnt == AW'(N - 1);
   assign last_k = k == AW'(VEC_S - 1);
   assign last_t = last_k && r == AW'(M_ROWS - 1);
   // s_ready is low throughout ISSUE, so the buffer is frozen while it is read
   always_ff @(posedge clk)
      if (xfer) mem[ld_cnt] <= bus.s_data;
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= LOAD;
         ld_cnt        <= '0;
         w_ptr         <= '0;
         r             <= '0;
         k             <= '0;
         gap           <= '0;
         bus.s_ready   <= 1'b0;
         bus.mac_a     <= '0;
         bus.mac_b     <= '0;
         bus.mac_x     <= '0;
         bus.mac_valid <= 1'b0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
      end else if (state == LOAD) begin
         bus.mac_valid <= 1'b0;
         bus.done      <= 1'b0;
         bus.busy      <= xfer || ld_cnt != '0;
         bus.s_ready   <= !(xfer && last_w);
         if (xfer) ld_cnt <= last_w ? '0 : ld_cnt + 1'b1;
         if (xfer && last_w) state <= ISSUE;
      end else if (gap != '0) begin
         bus.mac_valid <= 1'b0;
         gap           <= gap - 1'b1;
      end else begin
         bus.mac_a     <= mem[w_ptr];
         bus.mac_b     <= mem[AW'(MV) + k];
         bus.mac_x     <= mem[AW'(MV + VEC_S) + r];
         bus.mac_valid <= 1'b1;
         bus.done      <= last_t;
         w_ptr         <= last_t ? '0 : w_ptr + 1'b1;
         k             <= last_k ? '0 : k + 1'b1;
         r             <= last_t ? '0 : r + AW'(last_k);
         gap           <= last_t ? '0 : 4'(GAP);
         if (last_t) state <= LOAD;
      end
   end
endmodule

// File: tb/tb_mac_vec_feeder.sv
// tb_mac_vec_feeder: directed jobs against a GAP=0 and a GAP=2 feeder, checking triples, timing and MAC results.
module tb_mac_vec_feeder;
   logic       clk, reset, sel, s_valid;
   logic [7:0] s_data;
   int         errors = 0, checks = 0;
   int         n_trip, done_cyc;
   logic [23:0] trip [64];
   int          tcyc [64];
   localparam logic [23:0] T1E [9] = '{24'h02010A, 24'h00020A, 24'h00030A,
                                      24'h000114, 24'h020214, 24'h000314,
                                      24'h00011E, 24'h00021E, 24'h02031E};
   logic [7:0] w1 [15] = '{8'd2, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 8'd2, 8'd1, 8'd2, 8'd3, 8'd10, 8'd20, 8'd30};
   logic [7:0] w2 [15] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80,
                           8'h7F, 8'h7F, 8'h7F, 8'h00, 8'h00, 8'h00};
   mac_vec_feeder_if i0 ();
   mac_vec_feeder_if i2 ();
   mac_vec_feeder #(.GAP(0)) dut0 (.clk(clk), .reset(reset), .bus(i0.slave));
   mac_vec_feeder #(.GAP(2)) dut2 (.clk(clk), .reset(reset), .bus(i2.slave));
   assign i0.s_data  = s_data;
   assign i2.s_data  = s_data;
   assign i0.s_valid = s_valid & !sel;
   assign i2.s_valid = s_valid & sel;
   logic       o_ready, o_valid, o_busy, o_done;
   logic [23:0] o_abx;
   assign o_ready = sel ? i2.s_ready : i0.s_ready;
   assign o_valid = sel ? i2.mac_valid : i0.mac_valid;
   assign o_busy  = sel ? i2.busy : i0.busy;
   assign o_done  = sel ? i2.done : i0.done;
   assign o_abx   = sel ? {i2.mac_a, i2.mac_b, i2.mac_x} : {i0.mac_a, i0.mac_b, i0.mac_x};
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask
   // drives cnt words; with tog each accepted word is followed by two idle cycles carrying junk data
   task automatic load(input logic [7:0] w [15], input int cnt, input bit tog);
      int i = 0, tries = 0;
      logic rdy;
      while (i < cnt && tries < 200) begin
         s_valid = 1'b1;
         s_data  = w[i];
         rdy     = o_ready;
         @(negedge clk);
         tries++;
         if (rdy) i++;
         if (rdy && tog && i < cnt) begin
            s_valid = 1'b0;
            s_data  = 8'hEE;
            repeat (2) @(negedge clk);
         end
      end
      s_valid = 1'b0;
      s_data  = 8'h00;
      if (i < cnt) chk("load_timeout", i, cnt);
   endtask
   task automatic collect();
      n_trip   = 0;
      done_cyc = -1;
      for (int c = 0; c < 200 && done_cyc < 0; c++) begin
         if (o_valid && n_trip < 64) begin
            trip[n_trip] = o_abx;
            tcyc[n_trip] = c;
            n_trip++;
         end
         if (o_done) done_cyc = c;
         if (c == 0) chk("busy_issue", o_busy, 1);
         if (done_cyc < 0) @(negedge clk);
      end
      chk("n_trip", n_trip, 9);
      chk("done_with_last", done_cyc, n_trip > 0 ? tcyc[n_trip-1] : -2);
      @(negedge clk);
      chk("post_busy", o_busy, 0);
      chk("post_valid", o_valid, 0);
      chk("post_ready", o_ready, 1);
      chk("post_done", o_done, 0);
   endtask
   function automatic int mac_y(input int r);
      int y = 0;
      for (int i = 3 * r; i < 3 * r + 3 && i < n_trip; i++) begin
         if (i == 3 * r) y = int'(trip[i][7:0]);
         y += int'($signed(trip[i][23:16])) * int'($signed(trip[i][15:8]));
      end
      return y;
   endfunction
   task automatic chk_t1(input string tag);
      for (int i = 0; i < 9; i++) chk($sformatf("%s_trip%0d", tag, i), i < n_trip ? trip[i] : 24'hxxxxxx, T1E[i]);
      chk({tag, "_y0"}, mac_y(0), 12);
      chk({tag, "_y1"}, mac_y(1), 24);
      chk({tag, "_y2"}, mac_y(2), 36);
   endtask
   initial begin
      int n, seen;
      reset   = 1'b1;
      sel     = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_ready", o_ready, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_abx", o_abx, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", o_ready, 1);
      // T1: back-to-back issue, first triple one cycle after the last word lands
      load(w1, 15, 0);
      collect();
      chk("t1_first_cyc", tcyc[0], 1);
      chk("t1_last_cyc", tcyc[8], 9);
      chk_t1("t1");
      // T2: extreme signed values pass through bit-exact
      load(w2, 15, 0);
      collect();
      for (int i = 0; i < 9; i++) chk($sformatf("t2_trip%0d", i), trip[i], 24'h807F00);
      chk("t2_y0", mac_y(0), -48768);
      chk("t2_y2", mac_y(2), -48768);
      // T3: stalled stream with junk on idle cycles
      load(w1, 15, 1);
      collect();
      chk_t1("t3");
      // T4: GAP=2 feeder
      sel = 1'b1;
      @(negedge clk);
      chk("t4_ready", o_ready, 1);
      load(w1, 15, 0);
      collect();
      for (int i = 0; i < 9; i++) chk($sformatf("t4_cyc%0d", i), tcyc[i], 1 + 3 * i);
      chk("t4_span", tcyc[8] - tcyc[0] + 1, 25);
      chk_t1("t4");
      sel = 1'b0;
      // T5: reset discards a partial job
      load(w1, 7, 0);
      chk("t5_busy_partial", o_busy, 1);
      chk("t5_valid_partial", o_valid, 0);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_ready_rst", o_ready, 0);
      chk("t5_busy_rst", o_busy, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("t5_ready_after", o_ready, 1);
      load(w1, 15, 0);
      collect();
      chk_t1("t5");
      // T6: reset while the 5th triple is on the outputs
      load(w1, 15, 0);
      n    = 0;
      seen = 0;
      for (int c = 0; c < 100; c++) begin
         if (o_valid) n++;
         if (o_done) seen++;
         if (n == 5) break;
         @(negedge clk);
      end
      chk("t6_reach5", n, 5);
      chk("t6_abx5", o_abx, T1E[4]);
      reset = 1'b1;
      @(negedge clk);
      chk("t6_valid_next", o_valid, 0);
      chk("t6_ready_next", o_ready, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("t6_ready_follow", o_ready, 1);
      chk("t6_busy_follow", o_busy, 0);
      for (int c = 0; c < 20; c++) begin
         if (o_done) seen++;
         if (o_valid) n++;
         @(negedge clk);
      end
      chk("t6_no_done", seen, 0);
      chk("t6_no_more_valid", n, 5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
